// File: rtl/fibo_pkg.sv
// Shared types for the Fibonacci stream generator.
// Overflow policy and FSM state encodings.
package fibo_pkg;

    typedef enum logic [1:0] {
        FIBO_WRAP,
        FIBO_SAT,
        FIBO_STOP
    } fibo_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LAST,
        ST_DONE
    } fibo_state_e;

    function automatic fibo_mode_e to_mode(input int m);
        case (m)
            1:       return FIBO_SAT;
            2:       return FIBO_STOP;
            default: return FIBO_WRAP;
        endcase
    endfunction

endpackage

// File: rtl/fibo_step.sv
// One Fibonacci advance: adder plus overflow policy mux.
// Purely combinational; the caller owns all state.
module fibo_step
    import fibo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  fibo_mode_e       mode,
    output logic [WIDTH-1:0] next_b,
    output logic             carry
);

    logic [WIDTH:0] sum;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign carry = sum[WIDTH];

    always_comb begin
        next_b = sum[WIDTH-1:0];
        if (carry) begin
            unique case (mode)
                FIBO_WRAP: next_b = sum[WIDTH-1:0];
                FIBO_SAT:  next_b = '1;
                FIBO_STOP: next_b = b;
                default:   next_b = sum[WIDTH-1:0];
            endcase
        end
    end

endmodule

// File: rtl/fibo_stream_gen.sv
// Parametrised Fibonacci term source with valid/ready output,
// selectable overflow policy, runtime seeds and term counter.
module fibo_stream_gen
    import fibo_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               CNT_W  = 16,
    parameter logic [WIDTH-1:0] SEED_A = '0,
    parameter logic [WIDTH-1:0] SEED_B = WIDTH'(1),
    parameter int               MODE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_a_i,
    input  logic [WIDTH-1:0] seed_b_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             ovf_o,
    output logic [CNT_W-1:0] term_cnt_o,
    output logic             done_o
);

    localparam fibo_mode_e MODE_E = to_mode(MODE);

    fibo_state_e      state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] next_b;
    logic             carry;
    logic             hs;

    fibo_step #(.WIDTH(WIDTH)) u_step (
        .a      (a),
        .b      (b),
        .mode   (MODE_E),
        .next_b (next_b),
        .carry  (carry)
    );

    assign out_valid_o = en_i && (state == ST_RUN || state == ST_LAST);
    assign hs          = out_valid_o && out_ready_i;
    assign out_data_o  = a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a          <= SEED_A;
            b          <= SEED_B;
            state      <= ST_IDLE;
            ovf_o      <= 1'b0;
            term_cnt_o <= '0;
            done_o     <= 1'b0;
        end else if (clear_i) begin
            a          <= SEED_A;
            b          <= SEED_B;
            state      <= ST_IDLE;
            ovf_o      <= 1'b0;
            term_cnt_o <= '0;
            done_o     <= 1'b0;
        end else begin
            if (hs) begin
                term_cnt_o <= term_cnt_o + CNT_W'(1);
            end
            // A same-cycle load still consumes the presented term above.
            if (load_i) begin
                a      <= seed_a_i;
                b      <= seed_b_i;
                state  <= ST_RUN;
                done_o <= 1'b0;
            end else if (en_i) begin
                unique case (state)
                    ST_IDLE: state <= ST_RUN;
                    ST_RUN: begin
                        if (hs) begin
                            a <= b;
                            b <= next_b;
                            if (carry) begin
                                ovf_o <= 1'b1;
                                if (MODE_E == FIBO_STOP) begin
                                    state <= ST_LAST;
                                end
                            end
                        end
                    end
                    ST_LAST: begin
                        if (hs) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end
                    end
                    ST_DONE: state <= ST_DONE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fibo_stream_gen.sv
// Bench: three instances (WRAP, SATURATE, STOP) driven in lockstep
// and compared every cycle against an arithmetic reference model.
module tb_fibo_stream_gen;
    import fibo_pkg::*;

    localparam int W  = 8;
    localparam int CW = 16;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         en    = 1'b0;
    logic         clear = 1'b0;
    logic         load  = 1'b0;
    logic         ready = 1'b1;
    logic [W-1:0] sa    = '0;
    logic [W-1:0] sb    = '0;

    logic [W-1:0]  data  [3];
    logic          valid [3];
    logic          ovf   [3];
    logic          done  [3];
    logic [CW-1:0] cnt   [3];

    int checks = 0;
    int errors = 0;

    // Model: ph 0 waiting to start, 1 streaming, 2 final term, 3 finished
    int ma [3];
    int mb [3];
    int ph [3];
    int mc [3];
    bit mo [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fibo_stream_gen #(
            .WIDTH  (W),
            .CNT_W  (CW),
            .SEED_A (8'd0),
            .SEED_B (8'd1),
            .MODE   (g)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .en_i        (en),
            .clear_i     (clear),
            .load_i      (load),
            .seed_a_i    (sa),
            .seed_b_i    (sb),
            .out_data_o  (data[g]),
            .out_valid_o (valid[g]),
            .out_ready_i (ready),
            .ovf_o       (ovf[g]),
            .term_cnt_o  (cnt[g]),
            .done_o      (done[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit mvalid(input int i);
        return en && (ph[i] == 1 || ph[i] == 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ma[i] = 0;
            mb[i] = 1;
            ph[i] = 0;
            mc[i] = 0;
            mo[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            bit hs;
            int s;
            int nb;
            hs = mvalid(i) && ready;
            if (rst || clear) begin
                ma[i] = 0;
                mb[i] = 1;
                ph[i] = 0;
                mc[i] = 0;
                mo[i] = 1'b0;
            end else begin
                if (hs) mc[i] = (mc[i] + 1) % (1 << CW);
                if (load) begin
                    ma[i] = int'(sa);
                    mb[i] = int'(sb);
                    ph[i] = 1;
                end else if (en) begin
                    if (ph[i] == 0) begin
                        ph[i] = 1;
                    end else if (ph[i] == 1 && hs) begin
                        s  = ma[i] + mb[i];
                        nb = s;
                        if (s >= (1 << W)) begin
                            mo[i] = 1'b1;
                            if (i == 0) nb = s - (1 << W);
                            else if (i == 1) nb = (1 << W) - 1;
                            else begin
                                nb    = mb[i];
                                ph[i] = 2;
                            end
                        end
                        ma[i] = mb[i];
                        mb[i] = nb;
                    end else if (ph[i] == 2 && hs) begin
                        ph[i] = 3;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid%0d", i), 32'(valid[i]), 32'(mvalid(i)));
            chk($sformatf("data%0d", i), 32'(data[i]), ma[i]);
            chk($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(mo[i]));
            chk($sformatf("cnt%0d", i), 32'(cnt[i]), mc[i]);
            chk($sformatf("done%0d", i), 32'(done[i]), 32'(ph[i] == 3));
        end
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 unit later.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        step();

        en = 1'b1;
        for (int k = 0; k < 15; k++) step();
        chk("t1_cnt14", 32'(cnt[0]), 14);
        chk("t2_wrap121", 32'(data[0]), 121);
        chk("t3_sat255", 32'(data[1]), 255);
        chk("t4_stop_valid", 32'(valid[2]), 0);
        chk("t4_stop_cnt", 32'(cnt[2]), 14);
        step();
        chk("t2_wrap98", 32'(data[0]), 98);
        chk("t4_done", 32'(done[2]), 1);
        for (int k = 0; k < 4; k++) step();

        load = 1'b1;
        sa   = 8'd5;
        sb   = 8'd8;
        step();
        load = 1'b0;
        chk("t4_load_data", 32'(data[2]), 5);
        chk("t4_ovf_kept", 32'(ovf[2]), 1);
        for (int k = 0; k < 6; k++) step();

        for (int k = 0; k < 16; k++) begin
            ready = (k % 4 == 0) || (k % 4 == 3);
            step();
        end
        ready = 1'b1;

        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("t6_term3", 32'(data[0]), 3);
        load = 1'b1;
        sa   = 8'd100;
        sb   = 8'd50;
        step();
        load = 1'b0;
        chk("t6_cnt_load", 32'(cnt[0]), 5);
        for (int k = 0; k < 8; k++) step();

        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t6_async_valid", 32'(valid[i]), 0);
            chk("t6_async_data", 32'(data[i]), 0);
            chk("t6_async_cnt", 32'(cnt[i]), 0);
            chk("t6_async_ovf", 32'(ovf[i]), 0);
        end
        model_reset();
        step();
        rst = 1'b0;
        step();

        for (int k = 0; k < 600; k++) begin
            en    = ($urandom_range(9) != 0);
            ready = $urandom_range(1) == 1;
            load  = ($urandom_range(39) == 0);
            clear = ($urandom_range(59) == 0);
            sa    = W'($urandom);
            sb    = W'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
